// File: rtl/rmt_cfg_pkg.sv
// Shared constants for the RMT stage control-plane writer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package rmt_cfg_pkg;

   // Resource ids carried in the header beat
   localparam logic [7:0] RES_CAM = 8'h01;
   localparam logic [7:0] RES_ACT = 8'h02;

   // Header beat field offsets (LSB positions)
   localparam int HDR_RES_LSB   = 0;   // 8-bit resource id
   localparam int HDR_ADDR_LSB  = 8;   // 4-bit entry address
   localparam int HDR_STAGE_LSB = 12;  // 4-bit stage id

   // Payload beats per resource type
   localparam int CAM_BEATS = 8;       // 4 key beats then 4 mask beats
   localparam int ACT_BEATS = 3;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RECV_CAM = 3'd1,
      ST_RECV_ACT = 3'd2,
      ST_WRITE    = 3'd3,
      ST_DROP     = 3'd4
   } cfg_state_t;

endpackage

// File: rtl/cfg_beat_assembler.sv
// Indexed slot register file that collects payload beats into one wide entry.
// Latency: a beat written on an edge is visible on slots_dat right after it.
// Backpressure: none; writes whenever wr_en is high.
//
// Ports: clk; wr_en/wr_idx/wr_dat write one W-bit slot;
//        slots_dat exposes all N slots, slot 0 in the least significant bits.
module cfg_beat_assembler #(
   parameter int N     = 8,
   parameter int W     = 256,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [W-1:0]     wr_dat,
   output logic [N*W-1:0]   slots_dat
);

   // No reset: contents only reach the outputs once a full entry is written.
   logic [N-1:0][W-1:0] slot_q;

   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (wr_en && (wr_idx == IDX_W'(i))) begin
            slot_q[i] <= wr_dat;
         end
      end
   end

   assign slots_dat = slot_q;

endmodule

// File: rtl/lookup_cfg_writer.sv
// Control-packet writer: assembles CAM or action entries and strobes them into the lookup engine.
// Latency: write strobe one cycle after the final payload beat handshake.
// Backpressure: s_axis_tready low only during the single WRITE cycle.
//
// Ports: clk, rst_n (async, active-low);
//        s_axis_* 256-bit control stream input;
//        lookup_din/_mask/_addr/_en CAM write channel; action_data_in/_addr/_en action write channel;
//        cfg_err_cnt saturating malformed-packet count; cfg_busy high outside IDLE.
module lookup_cfg_writer
   import rmt_cfg_pkg::*;
#(
   parameter int STAGE        = 0,
   parameter int C_DATA_WIDTH = 256,
   parameter int KEY_W        = 1024,
   parameter int ACT_LEN      = 25,
   parameter int ADDR_W       = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                    s_axis_tvalid,
   input  logic                    s_axis_tlast,
   output logic                    s_axis_tready,
   output logic [KEY_W-1:0]        lookup_din,
   output logic [KEY_W-1:0]        lookup_din_mask,
   output logic [ADDR_W-1:0]       lookup_din_addr,
   output logic                    lookup_din_en,
   output logic [ACT_LEN*25-1:0]   action_data_in,
   output logic [ADDR_W-1:0]       action_addr,
   output logic                    action_en,
   output logic [7:0]              cfg_err_cnt,
   output logic                    cfg_busy
);

   localparam int ACT_W      = ACT_LEN * 25;
   localparam int CNT_W      = $clog2(CAM_BEATS);
   localparam int ACT_IDX_W  = $clog2(ACT_BEATS);
   localparam logic [3:0] STAGE_ID = 4'(STAGE);

   cfg_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q;
   logic              is_cam_q;
   logic [7:0]        err_q;

   logic              beat_hs;
   logic              err_inc;
   logic              hdr_ld;
   logic              cam_wr;
   logic              act_wr;

   logic [7:0]        hdr_res;
   logic [ADDR_W-1:0] hdr_addr;
   logic [3:0]        hdr_stage;

   logic [CAM_BEATS*C_DATA_WIDTH-1:0] cam_slots;
   logic [ACT_BEATS*C_DATA_WIDTH-1:0] act_slots;
   logic                              act_pad_unused;

   logic                cam_wr_cyc;
   logic                act_wr_cyc;
   logic [KEY_W-1:0]    din_q;
   logic [KEY_W-1:0]    mask_q;
   logic [ADDR_W-1:0]   cam_addr_q;
   logic [ACT_W-1:0]    act_q;
   logic [ADDR_W-1:0]   act_addr_q;

   assign hdr_res   = s_axis_tdata[HDR_RES_LSB +: 8];
   assign hdr_addr  = s_axis_tdata[HDR_ADDR_LSB +: ADDR_W];
   assign hdr_stage = s_axis_tdata[HDR_STAGE_LSB +: 4];

   assign s_axis_tready = (state_q != ST_WRITE);
   assign beat_hs       = s_axis_tvalid && (state_q != ST_WRITE);
   assign cfg_busy      = (state_q != ST_IDLE);
   assign cfg_err_cnt   = err_q;

   // ---------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_inc = 1'b0;
      hdr_ld  = 1'b0;
      cam_wr  = 1'b0;
      act_wr  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (beat_hs) begin
               // A packet that ends on its header is malformed whatever it targets.
               if (s_axis_tlast) begin
                  err_inc = 1'b1;
               end else if (hdr_stage != STAGE_ID) begin
                  state_d = ST_DROP;
               end else if (hdr_res == RES_CAM) begin
                  hdr_ld  = 1'b1;
                  cnt_d   = '0;
                  state_d = ST_RECV_CAM;
               end else if (hdr_res == RES_ACT) begin
                  hdr_ld  = 1'b1;
                  cnt_d   = '0;
                  state_d = ST_RECV_ACT;
               end else begin
                  err_inc = 1'b1;
                  state_d = ST_DROP;
               end
            end
         end
         ST_RECV_CAM: begin
            if (beat_hs) begin
               cam_wr = 1'b1;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(CAM_BEATS - 1)) begin
                  if (s_axis_tlast) begin
                     state_d = ST_WRITE;
                  end else begin
                     err_inc = 1'b1;
                     state_d = ST_DROP;
                  end
               end else if (s_axis_tlast) begin
                  err_inc = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_RECV_ACT: begin
            if (beat_hs) begin
               act_wr = 1'b1;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(ACT_BEATS - 1)) begin
                  if (s_axis_tlast) begin
                     state_d = ST_WRITE;
                  end else begin
                     err_inc = 1'b1;
                     state_d = ST_DROP;
                  end
               end else if (s_axis_tlast) begin
                  err_inc = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_WRITE: begin
            state_d = ST_IDLE;
         end
         ST_DROP: begin
            if (beat_hs && s_axis_tlast) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Beat counter, latched header fields, error counter
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         addr_q   <= '0;
         is_cam_q <= 1'b0;
         err_q    <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (hdr_ld) begin
            addr_q   <= hdr_addr;
            is_cam_q <= (hdr_res == RES_CAM);
         end
         if (err_inc && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
         end
      end
   end

   // ---------------------------------------------------------------
   // Payload assembly
   // ---------------------------------------------------------------
   cfg_beat_assembler #(
      .N (CAM_BEATS),
      .W (C_DATA_WIDTH)
   ) u_cam_asm (
      .clk       (clk),
      .wr_en     (cam_wr),
      .wr_idx    (cnt_q),
      .wr_dat    (s_axis_tdata),
      .slots_dat (cam_slots)
   );

   cfg_beat_assembler #(
      .N (ACT_BEATS),
      .W (C_DATA_WIDTH)
   ) u_act_asm (
      .clk       (clk),
      .wr_en     (act_wr),
      .wr_idx    (cnt_q[ACT_IDX_W-1:0]),
      .wr_dat    (s_axis_tdata),
      .slots_dat (act_slots)
   );

   // Top bits of the three action beats are padding.
   assign act_pad_unused = ^act_slots[ACT_BEATS*C_DATA_WIDTH-1:ACT_W];

   // ---------------------------------------------------------------
   // Output channel
   // ---------------------------------------------------------------
   // The final beat lands in the assembler on the edge that enters WRITE, so
   // during WRITE the entry is driven straight from the assembler; the
   // holding registers capture it at the end of WRITE and keep it afterwards.
   assign cam_wr_cyc = (state_q == ST_WRITE) && is_cam_q;
   assign act_wr_cyc = (state_q == ST_WRITE) && !is_cam_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         din_q      <= '0;
         mask_q     <= '0;
         cam_addr_q <= '0;
         act_q      <= '0;
         act_addr_q <= '0;
      end else begin
         if (cam_wr_cyc) begin
            din_q      <= cam_slots[KEY_W-1:0];
            mask_q     <= cam_slots[2*KEY_W-1:KEY_W];
            cam_addr_q <= addr_q;
         end
         if (act_wr_cyc) begin
            act_q      <= act_slots[ACT_W-1:0];
            act_addr_q <= addr_q;
         end
      end
   end

   assign lookup_din      = cam_wr_cyc ? cam_slots[KEY_W-1:0]       : din_q;
   assign lookup_din_mask = cam_wr_cyc ? cam_slots[2*KEY_W-1:KEY_W] : mask_q;
   assign lookup_din_addr = cam_wr_cyc ? addr_q                     : cam_addr_q;
   assign lookup_din_en   = cam_wr_cyc;

   assign action_data_in  = act_wr_cyc ? act_slots[ACT_W-1:0] : act_q;
   assign action_addr     = act_wr_cyc ? addr_q               : act_addr_q;
   assign action_en       = act_wr_cyc;

endmodule
